// File: rtl/pwm_pkg.sv
// Shared types and default widths for the multi-channel PWM generator.
package pwm_pkg;

    localparam int unsigned PWM_NUM_CH_DEF  = 16;
    localparam int unsigned PWM_CNT_W_DEF   = 8;
    localparam int unsigned PWM_PRESC_W_DEF = 8;

    // Counting mode held in the mode shadow.
    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    // Direction of the centre-aligned counter; edge mode always counts up.
    typedef enum logic {
        DirUp   = 1'b0,
        DirDown = 1'b1
    } pwm_dir_e;

endpackage

// File: rtl/pwm_multichannel_if.sv
// Configuration and output bundle between the register bank and the PWM block.
// The register bank is the master; the PWM generator is the slave.
interface pwm_multichannel_if
    import pwm_pkg::*;
#(
    parameter int unsigned NUM_CH  = PWM_NUM_CH_DEF,
    parameter int unsigned CNT_W   = PWM_CNT_W_DEF,
    parameter int unsigned PRESC_W = PWM_PRESC_W_DEF
);

    logic [NUM_CH-1:0]       en_out;
    logic [NUM_CH-1:0]       en_pwm;
    logic [NUM_CH*CNT_W-1:0] duty;
    logic [CNT_W-1:0]        period;
    logic [PRESC_W-1:0]      prescale;
    logic                    center_mode;
    logic                    cfg_load;
    logic [NUM_CH-1:0]       out;
    logic                    boundary;

    modport master (
        output en_out,
        output en_pwm,
        output duty,
        output period,
        output prescale,
        output center_mode,
        output cfg_load,
        input  out,
        input  boundary
    );

    modport slave (
        input  en_out,
        input  en_pwm,
        input  duty,
        input  period,
        input  prescale,
        input  center_mode,
        input  cfg_load,
        output out,
        output boundary
    );

endinterface

// File: rtl/pwm_timebase.sv
// Shared timebase: prescaler, edge/centre counter, period and mode shadows,
// and the boundary / shadow-load decision used by every channel.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int unsigned CNT_W   = PWM_CNT_W_DEF,
    parameter int unsigned PRESC_W = PWM_PRESC_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [CNT_W-1:0]   period_i,
    input  logic [PRESC_W-1:0] prescale_i,
    input  logic               center_mode_i,
    input  logic               cfg_load_i,
    output logic [CNT_W-1:0]   cnt_o,
    output logic               boundary_comb_o,
    output logic               load_now_o
);

    logic [PRESC_W-1:0] presc_cnt_q, presc_cnt_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   period_sh_q, period_sh_d;
    pwm_dir_e           dir_q, dir_d;
    pwm_mode_e          mode_sh_q, mode_sh_d;
    logic               pending_q, pending_d;
    logic               tick;
    logic               period_zero;
    logic               period_one;

    assign period_zero = (period_sh_q == '0);
    assign period_one  = (period_sh_q == CNT_W'(1));
    assign cnt_o       = cnt_q;

    // State register for the timebase, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_cnt_q <= '0;
            cnt_q       <= '0;
            period_sh_q <= '0;
            dir_q       <= DirUp;
            mode_sh_q   <= PWM_EDGE;
            pending_q   <= 1'b0;
        end else begin
            presc_cnt_q <= presc_cnt_d;
            cnt_q       <= cnt_d;
            period_sh_q <= period_sh_d;
            dir_q       <= dir_d;
            mode_sh_q   <= mode_sh_d;
            pending_q   <= pending_d;
        end
    end

    // Outputs: prescaler tick, period boundary and the shadow-load strobe.
    always_comb begin
        // >= rather than == so a live prescale lowered below the current
        // count wraps on the next clock instead of running the full width.
        tick            = (presc_cnt_q >= prescale_i);
        boundary_comb_o = 1'b0;
        if (tick) begin
            if (period_zero) begin
                boundary_comb_o = 1'b1;
            end else if (mode_sh_q == PWM_EDGE) begin
                boundary_comb_o = (cnt_q >= period_sh_q);
            end else begin
                // With period 1 the top and the 1->0 turn are the same count.
                boundary_comb_o = (cnt_q == CNT_W'(1)) && ((dir_q == DirDown) || period_one);
            end
        end
        load_now_o = boundary_comb_o && (pending_q || cfg_load_i);
    end

    // Next state: prescaler wrap, counter stepping, shadow capture.
    always_comb begin
        presc_cnt_d = tick ? '0 : presc_cnt_q + 1'b1;
        cnt_d       = cnt_q;
        dir_d       = dir_q;
        period_sh_d = period_sh_q;
        mode_sh_d   = mode_sh_q;
        pending_d   = pending_q | cfg_load_i;

        if (load_now_o) begin
            // New shadows start a fresh cycle from the bottom.
            cnt_d       = '0;
            dir_d       = DirUp;
            period_sh_d = period_i;
            mode_sh_d   = center_mode_i ? PWM_CENTER : PWM_EDGE;
            pending_d   = 1'b0;
        end else if (tick) begin
            if (period_zero) begin
                cnt_d = '0;
                dir_d = DirUp;
            end else if (mode_sh_q == PWM_EDGE) begin
                cnt_d = boundary_comb_o ? '0 : cnt_q + 1'b1;
                dir_d = DirUp;
            end else if (dir_q == DirUp) begin
                if (cnt_q >= period_sh_q) begin
                    if (period_one) begin
                        cnt_d = '0;
                        dir_d = DirUp;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                        dir_d = DirDown;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d = '0;
                    dir_d = DirUp;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pwm_multichannel.sv
// Multi-channel PWM generator: shared timebase, per-channel shadowed duty,
// comparators and registered outputs with per-channel enables.
module pwm_multichannel
    import pwm_pkg::*;
#(
    parameter int unsigned NUM_CH  = PWM_NUM_CH_DEF,
    parameter int unsigned CNT_W   = PWM_CNT_W_DEF,
    parameter int unsigned PRESC_W = PWM_PRESC_W_DEF
) (
    input logic                clk,
    input logic                rst,
    pwm_multichannel_if.slave  bus
);

    logic [CNT_W-1:0]  cnt;
    logic              boundary_comb;
    logic              load_now;
    logic [CNT_W-1:0]  duty_sh_q [NUM_CH];
    logic [CNT_W-1:0]  duty_sh_d [NUM_CH];
    logic [NUM_CH-1:0] pwm;
    logic [NUM_CH-1:0] out_q, out_d;
    logic              boundary_q;

    pwm_timebase #(
        .CNT_W   (CNT_W),
        .PRESC_W (PRESC_W)
    ) u_timebase (
        .clk             (clk),
        .rst             (rst),
        .period_i        (bus.period),
        .prescale_i      (bus.prescale),
        .center_mode_i   (bus.center_mode),
        .cfg_load_i      (bus.cfg_load),
        .cnt_o           (cnt),
        .boundary_comb_o (boundary_comb),
        .load_now_o      (load_now)
    );

    // Per-channel duty shadow capture and comparator.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign duty_sh_d[g] = load_now ? bus.duty[g*CNT_W +: CNT_W] : duty_sh_q[g];
        assign pwm[g]       = (cnt < duty_sh_q[g]);
    end

    // Output gating: enables act immediately, bypassing the shadows.
    always_comb begin
        out_d = bus.en_out & (~bus.en_pwm | pwm);
    end

    // Shadow and output registers, synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++) begin
                duty_sh_q[i] <= '0;
            end
            out_q      <= '0;
            boundary_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                duty_sh_q[i] <= duty_sh_d[i];
            end
            out_q      <= out_d;
            boundary_q <= boundary_comb;
        end
    end

    assign bus.out      = out_q;
    assign bus.boundary = boundary_q;

endmodule

// File: tb/tb_pwm_multichannel.sv
// Self-checking bench for pwm_multichannel: table-driven configurations
// measured over one full period each, plus hand sequences for shadow
// update timing, enables and mid-run reset.
module tb_pwm_multichannel;
    import pwm_pkg::*;

    localparam int unsigned NUM_CH  = 16;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned PRESC_W = 8;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pwm_multichannel_if #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .PRESC_W (PRESC_W)
    ) bus ();

    pwm_multichannel #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .PRESC_W (PRESC_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        int period;
        int prescale;
        bit center;
        int d0;
        int d1;
        int d2;
        int exp_len;
        int exp_h0;
        int exp_h1;
        int exp_h2;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   exp_q[$];
    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_duty(input int ch, input int val);
        bus.duty[ch*CNT_W +: CNT_W] = CNT_W'(val);
    endtask

    // Wait until a boundary pulse is visible, starting with the current sample.
    task automatic wait_boundary(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (bus.boundary) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    // Entered in the cycle right after a boundary pulse was seen (cnt = 0).
    // Counts clocks and high outputs until the next boundary pulse.
    task automatic measure(input int load_at, input int new_d0, output int len,
                           output int h0, output int h1, output int h2, output bit ok);
        len = 0;
        h0  = 0;
        h1  = 0;
        h2  = 0;
        ok  = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            if (i == 0 && new_d0 >= 0) set_duty(0, new_d0);
            bus.cfg_load = (i == load_at);
            step();
            len++;
            h0 += int'(bus.out[0]);
            h1 += int'(bus.out[1]);
            h2 += int'(bus.out[2]);
            if (bus.boundary) begin
                ok = 1'b1;
                break;
            end
        end
        bus.cfg_load = 1'b0;
    endtask

    // Drive a configuration, strobe cfg_load and sync to the loading boundary.
    task automatic apply_cfg(input string name, input int p, input int ps, input bit c,
                             input int d0, input int d1, input int d2);
        bit ok;
        bus.period      = CNT_W'(p);
        bus.prescale    = PRESC_W'(ps);
        bus.center_mode = c;
        set_duty(0, d0);
        set_duty(1, d1);
        set_duty(2, d2);
        bus.cfg_load = 1'b1;
        step();
        bus.cfg_load = 1'b0;
        wait_boundary(ok);
        check({name, " load boundary timeout"}, int'(ok), 1);
    endtask

    initial begin
        int len, h0, h1, h2;
        bit ok;
        int ones;

        vecs[0] = '{period: 9, prescale: 0, center: 1'b0, d0: 3, d1: 0, d2: 12,
                    exp_len: 10, exp_h0: 3, exp_h1: 0, exp_h2: 10};
        vecs[1] = '{period: 9, prescale: 3, center: 1'b0, d0: 3, d1: 0, d2: 12,
                    exp_len: 40, exp_h0: 12, exp_h1: 0, exp_h2: 40};
        vecs[2] = '{period: 4, prescale: 0, center: 1'b1, d0: 2, d1: 0, d2: 12,
                    exp_len: 8, exp_h0: 3, exp_h1: 0, exp_h2: 8};
        vecs[3] = '{period: 4, prescale: 1, center: 1'b1, d0: 2, d1: 4, d2: 5,
                    exp_len: 16, exp_h0: 6, exp_h1: 14, exp_h2: 16};
        vecs[4] = '{period: 5, prescale: 2, center: 1'b0, d0: 6, d1: 5, d2: 1,
                    exp_len: 18, exp_h0: 18, exp_h1: 15, exp_h2: 3};
        vecs[5] = '{period: 0, prescale: 0, center: 1'b0, d0: 3, d1: 0, d2: 1,
                    exp_len: 1, exp_h0: 1, exp_h1: 0, exp_h2: 1};
        vecs[6] = '{period: 0, prescale: 2, center: 1'b1, d0: 1, d1: 0, d2: 0,
                    exp_len: 3, exp_h0: 3, exp_h1: 0, exp_h2: 0};

        rst             = 1'b1;
        bus.en_out      = '1;
        bus.en_pwm      = '1;
        bus.duty        = '0;
        bus.period      = '0;
        bus.prescale    = '0;
        bus.center_mode = 1'b0;
        bus.cfg_load    = 1'b0;

        // Reset state, then zero shadows: outputs low, boundary every tick.
        step();
        step();
        step();
        check("reset out", int'(bus.out), 0);
        check("reset boundary", int'(bus.boundary), 0);
        rst = 1'b0;
        step();
        step();
        check("post-reset out low", int'(bus.out), 0);
        check("post-reset period0 boundary", int'(bus.boundary), 1);

        // Table-driven configurations, one measured period each.
        foreach (vecs[k]) begin
            string nm;
            nm = $sformatf("vec%0d", k);
            exp_q.push_back(vecs[k].exp_len);
            exp_q.push_back(vecs[k].exp_h0);
            exp_q.push_back(vecs[k].exp_h1);
            exp_q.push_back(vecs[k].exp_h2);
            apply_cfg(nm, vecs[k].period, vecs[k].prescale, vecs[k].center,
                      vecs[k].d0, vecs[k].d1, vecs[k].d2);
            measure(-1, -1, len, h0, h1, h2, ok);
            check({nm, " period timeout"}, int'(ok), 1);
            check({nm, " period clocks"}, len, exp_q.pop_front());
            check({nm, " out0 high"}, h0, exp_q.pop_front());
            check({nm, " out1 high"}, h1, exp_q.pop_front());
            check({nm, " out2 high"}, h2, exp_q.pop_front());
        end

        // Shadowed duty update: cfg_load mid-period, then in the boundary cycle.
        apply_cfg("glitch", 9, 0, 1'b0, 3, 0, 12);
        exp_q.push_back(3);
        exp_q.push_back(7);
        exp_q.push_back(7);
        exp_q.push_back(2);
        measure(5, 7, len, h0, h1, h2, ok);
        check("glitch mid-load current period", h0, exp_q.pop_front());
        measure(-1, -1, len, h0, h1, h2, ok);
        check("glitch mid-load next period", h0, exp_q.pop_front());
        measure(9, 2, len, h0, h1, h2, ok);
        check("glitch boundary-load current period", h0, exp_q.pop_front());
        measure(-1, -1, len, h0, h1, h2, ok);
        check("glitch boundary-load next period", h0, exp_q.pop_front());
        check("glitch period clocks", len, 10);

        // Enables: static high with en_pwm=0, forced low one clock after en_out=0.
        bus.en_pwm[5] = 1'b0;
        step();
        ones = 0;
        for (int i = 0; i < 12; i++) begin
            ones += int'(bus.out[5]);
            step();
        end
        check("en_pwm=0 static high clocks", ones, 12);
        bus.en_out[5] = 1'b0;
        step();
        check("en_out=0 forces low", int'(bus.out[5]), 0);
        bus.en_out[5] = 1'b1;
        bus.en_pwm[5] = 1'b1;

        // Mid-run reset with ch0 high, then a clean restart from cnt 0.
        wait_boundary(ok);
        check("pre-reset sync timeout", int'(ok), 1);
        step();
        check("pre-reset out0 high", int'(bus.out[0]), 1);
        rst = 1'b1;
        step();
        check("mid-reset out", int'(bus.out), 0);
        check("mid-reset boundary", int'(bus.boundary), 0);
        step();
        step();
        check("mid-reset held out", int'(bus.out), 0);
        rst = 1'b0;
        step();
        check("after mid-reset out low", int'(bus.out), 0);
        apply_cfg("restart", 9, 0, 1'b0, 3, 0, 12);
        measure(-1, -1, len, h0, h1, h2, ok);
        check("restart period clocks", len, 10);
        check("restart out0 high", h0, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
